// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response and decoder handshake bundle
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with credit-limited prefetch FIFO and redirect flush
module fetch_unit #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RST_PC_ADDRESS = '0,
    parameter int              DEPTH          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            j,
    input  logic [XLEN-1:0] jump_pc,
    fetch_unit_if.master    bus,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [AW-1:0]   ONE_P   = AW'(1);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    typedef enum logic {FETCH, FAULT} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [31:0]     fifo_data [DEPTH];
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            rsp;
    logic            push;
    logic            pop;

    // Credit covers buffered plus in-flight words, so a returning word always has a slot.
    assign in_use             = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = rst_n && (state == FETCH) && !j && (in_use < DEPTH_W);
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.instruction    = fifo_data[rd_ptr];
    assign bus.inst_pc        = fifo_pc[rd_ptr];

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp      = bus.imem_rsp_valid;
    assign push     = rsp && !j && (drop == '0);
    assign pop      = bus.inst_valid && bus.inst_ready && !j;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            fetch_pc    <= RST_PC_ADDRESS;
            rsp_pc      <= RST_PC_ADDRESS;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (j) begin
            // Everything still in flight after this edge belongs to the old path.
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            drop        <= outstanding - CW'(rsp);
            outstanding <= outstanding - CW'(rsp);
            fetch_pc    <= jump_pc;
            rsp_pc      <= jump_pc;
            if (jump_pc[1:0] != 2'b00) begin
                state       <= FAULT;
                fetch_fault <= 1'b1;
                fault_pc    <= jump_pc;
            end else begin
                state       <= FETCH;
                fetch_fault <= 1'b0;
            end
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp);
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            if (rsp) begin
                if (drop != '0) begin
                    drop <= drop - ONE_C;
                end else begin
                    rsp_pc <= rsp_pc + STEP;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && (count == FULL_C)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        j;
    logic [31:0] jump_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic        j1;
    logic [31:0] jump_pc1;
    logic        fetch_fault1;
    logic [31:0] fault_pc1;

    fetch_unit_if #(.XLEN(32)) bus  ();
    fetch_unit_if #(.XLEN(32)) bus1 ();

    fetch_unit #(.XLEN(32), .RST_PC_ADDRESS(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .j(j), .jump_pc(jump_pc), .bus(bus),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    fetch_unit #(.XLEN(32), .RST_PC_ADDRESS(32'hFFFF_FFF8), .DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .j(j1), .jump_pc(jump_pc1), .bus(bus1),
        .fetch_fault(fetch_fault1), .fault_pc(fault_pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Memory for dut: responds mem_lat cycles after acceptance, in order.
    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t pend_q[$];
    int    ncyc = 0;

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus.imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend_q.delete();
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due == ncyc) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = word_of(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end
                if (bus.imem_req_valid && bus.imem_req_ready)
                    pend_q.push_back('{ncyc + mem_lat, bus.imem_req_addr});
            end
            ncyc++;
        end
    end

    // Zero-wait memory for dut1.
    logic        prev_fire1;
    logic [31:0] prev_addr1;
    initial begin
        bus1.imem_rsp_valid = 1'b0;
        bus1.imem_rsp_data  = '0;
        prev_fire1 = 1'b0;
        prev_addr1 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus1.imem_rsp_valid = 1'b0;
                prev_fire1 = 1'b0;
            end else begin
                bus1.imem_rsp_valid = prev_fire1;
                bus1.imem_rsp_data  = word_of(prev_addr1);
                prev_fire1 = bus1.imem_req_valid && bus1.imem_req_ready;
                prev_addr1 = bus1.imem_req_addr;
            end
        end
    end

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic        jv;
        logic [31:0] jpc;
        logic        rrdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic        e_flt;
        logic [31:0] e_fpc;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic rstn, input logic rdy, input logic jv, input logic [31:0] jpc,
                                input logic rrdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_pc, input logic e_flt,
                                input logic [31:0] e_fpc);
        vec_t v;
        v.rstn = rstn; v.rdy = rdy; v.jv = jv; v.jpc = jpc; v.rrdy = rrdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        v.e_flt = e_flt; v.e_fpc = e_fpc;
        vecs.push_back(v);
    endfunction

    task automatic redirect_case(input string tag, input int lat, input int k, input logic [31:0] tgt);
        logic found;
        @(posedge clk); #1;
        rst_n = 1'b0; j = 1'b0; bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b1; mem_lat = lat;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (k) @(posedge clk);
        #1;
        j = 1'b1; jump_pc = tgt; bus.inst_ready = 1'b1;
        @(negedge clk);
        check({tag, "_req_in_j"}, lat, 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk); #1;
        j = 1'b0;
        @(negedge clk);
        check({tag, "_flushed"}, lat, 32'(bus.inst_valid), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.inst_valid) found = 1'b1;
        end
        check({tag, "_first_seen"}, lat, 32'(found), 32'd1);
        check({tag, "_first_pc"}, lat, bus.inst_pc, tgt);
        check({tag, "_first_word"}, lat, bus.instruction, word_of(tgt));
        @(negedge clk);
        check({tag, "_second_pc"}, lat, bus.inst_pc, tgt + 32'd4);
        check({tag, "_second_word"}, lat, bus.instruction, word_of(tgt + 32'd4));
    endtask

    initial begin
        logic found;
        rst_n = 1'b0; j = 1'b0; jump_pc = '0;
        bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b0;
        j1 = 1'b0; jump_pc1 = '0; bus1.inst_ready = 1'b1; bus1.imem_req_ready = 1'b1;

        // Streaming from reset, one instruction per cycle from cycle 2.
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            add(1, 1, 0, 0, 1, 1, 32'(4 * i), i >= 2, 32'(4 * (i - 2)), 0, 0);
        // Decoder stalled: four requests fill the credit, then drain in order.
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 0, 1, 1, 32'(4 * i), i >= 2, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 1, 0, 0, 1, 1, 32'(16 + 4 * i), 1, 32'(4 + 4 * i), 0, 0);
        // Misaligned redirects, then recovery with an aligned target.
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 32'h102, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 32'h102);
        add(1, 1, 1, 32'h103, 1, 0, 0, 0, 0, 1, 32'h102);
        add(1, 1, 1, 32'h200, 1, 0, 0, 0, 0, 1, 32'h103);
        add(1, 1, 0, 0, 1, 1, 32'h200, 0, 0, 0, 32'h103);
        add(1, 1, 0, 0, 1, 1, 32'h204, 0, 0, 0, 32'h103);
        add(1, 1, 0, 0, 1, 1, 32'h208, 1, 32'h200, 0, 32'h103);
        add(1, 1, 0, 0, 1, 1, 32'h20C, 1, 32'h204, 0, 32'h103);

        mem_lat = 1;
        foreach (vecs[k]) begin
            @(posedge clk); #1;
            rst_n = vecs[k].rstn; bus.inst_ready = vecs[k].rdy; j = vecs[k].jv;
            jump_pc = vecs[k].jpc; bus.imem_req_ready = vecs[k].rrdy;
            @(negedge clk);
            check("req_valid", k, 32'(bus.imem_req_valid), 32'(vecs[k].e_req));
            if (vecs[k].e_req) check("req_addr", k, bus.imem_req_addr, vecs[k].e_addr);
            check("inst_valid", k, 32'(bus.inst_valid), 32'(vecs[k].e_iv));
            if (vecs[k].e_iv) begin
                check("inst_pc", k, bus.inst_pc, vecs[k].e_pc);
                check("instruction", k, bus.instruction, word_of(vecs[k].e_pc));
            end
            check("fetch_fault", k, 32'(fetch_fault), 32'(vecs[k].e_flt));
            check("fault_pc", k, fault_pc, vecs[k].e_fpc);
        end

        // Reset PC near the top of the address space wraps through zero.
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus1.inst_valid) found = 1'b1;
        end
        check("wrap_first_seen", 0, 32'(found), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("wrap_pc", i, bus1.inst_pc, 32'hFFFF_FFF8 + 32'(4 * i));
            check("wrap_word", i, bus1.instruction, word_of(32'hFFFF_FFF8 + 32'(4 * i)));
            @(negedge clk);
        end
        check("wrap_fault", 0, 32'(fetch_fault1), 32'd0);
        check("wrap_fault_pc", 0, fault_pc1, 32'd0);

        // Slow memory with two words in flight at the redirect.
        redirect_case("stale2", 3, 2, 32'h100);
        // Redirect with a response arriving and a pop asserted on a nearly full FIFO.
        redirect_case("rsp_j_full", 1, 4, 32'h40);
        // Same, with one more word still in flight that must be dropped later.
        redirect_case("rsp_j_drop", 2, 4, 32'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
